inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of inst_decoder in the 16-bit, 4-register processor.
- Holds the PC and issues word reads to instruction memory, one outstanding request at a time; memory latency is variable.
- Buffers returned instructions in a small prefetch queue and presents them to the decoder with a valid/ready handshake.
- Supports PC redirect with flush for branches and jumps.

Parameters:
- PC_WIDTH, 8, width of PC and instruction memory address (word addressed).
- DEPTH, 2, prefetch queue entries (power of two, >= 1).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  memory read request.
- imem_addr  output  PC_WIDTH  read address; stable while imem_req is high and not acked.
- imem_ack  input  1  read complete; imem_rdata valid this cycle; may arrive in the same cycle as imem_req.
- imem_rdata  input  16  instruction word.
- redirect_valid  input  1  load a new PC and flush.
- redirect_pc  input  PC_WIDTH  target PC.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decoder accepts the head.
- instruction  output  16  queue head instruction; feeds inst_decoder.instruction.
- inst_pc  output  PC_WIDTH  PC of the queue head.
- halted  output  1  halt detected (HALT_DETECT_EN only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous):
  - pc=RESET_PC; queue empty; no request outstanding; discard flag clear.
  - imem_req=0, inst_valid=0, halted=0, instruction=0, inst_pc=0.
- Issue: imem_req asserts when no request is outstanding, occupancy+0 < DEPTH, and not halted.
  - imem_addr=pc.
  - Once asserted, req and addr hold until imem_ack.
- Ack:
  - Rising edge with req&ack: push {pc_of_request, imem_rdata} unless discard is set; then pc<=pc+1, wrapping 2^PC_WIDTH-1 -> 0.
  - Back-to-back operation is allowed: with zero-latency memory and no backpressure, one instruction per cycle.
- Output:
  - inst_valid = queue not empty; instruction/inst_pc = head (registered storage, combinational read).
  - Pop on inst_valid&inst_ready.
  - Push and pop in the same cycle are legal.
  - Overflow is impossible because issue accounts for the outstanding request.
- Backpressure: while inst_ready=0, head values are held stable.
- Redirect (synchronous, highest priority):
  - On redirect_valid at a rising edge: queue flushed (the same-cycle pop still counts as delivered), pc<=redirect_pc, halted<=0.
  - If a request is outstanding and not acked that cycle, set discard. The request keeps its old address until acked, its data is dropped, then discard clears.
  - The first fetch from redirect_pc issues the cycle after discard clears, or the cycle after redirect if nothing was outstanding.
  - A redirect coinciding with an ack drops that ack's data.
  - Repeated redirects: the last one wins.
- Reset mid-operation: everything returns to reset values immediately. The memory must abandon any in-flight access on reset.

Optional Feature:
- Macro: HALT_DETECT_EN.
- Defined:
  - When an enqueued instruction has opcode bits[15:12]=4'hF, halted<=1 and no further requests issue.
  - Queued instructions, including the halt, still drain to the decoder.
  - Only redirect or reset clears halted.
- Undefined: opcode 4'hF is fetched like any other instruction; halted is constant 0.

Test Plan:
- Reset, zero-latency memory returning 16'h1000+addr, inst_ready=1 -> after reset, one instruction per cycle: pc 0,1,2,… with instruction 16'h1000,16'h1001,…; no gaps.
- Memory latency 3 cycles, inst_ready=0 -> queue fills with pc0, pc1 (DEPTH=2); imem_req stays 0 afterwards; head holds 16'h1000 stable. Raise inst_ready -> delivers in order, fetching resumes.
- Redirect to 8'h40 while a request to pc 5 is pending (latency 2) -> pc 5 data not delivered; next request addr 8'h40; first inst_pc after redirect = 8'h40.
- Redirect in the same cycle as ack and as pop -> popped instruction counted once, acked data dropped, queue empty next cycle, next addr = redirect_pc.
- Redirect to 8'hFE, run 4 fetches -> addresses FE, FF, 00, 01.
- HALT_DETECT_EN defined, memory returns 16'hF000 at pc 3 -> pcs 0–3 delivered, halted=1, no req after pc 3. Redirect to 0 clears halted and refetches. Macro undefined: fetch continues past pc 3, halted=0.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, single-outstanding imem reads, prefetch queue, redirect/flush.
// Optional halt detection on opcode 4'hF is enabled by defining HALT_DETECT_EN.
module inst_fetch #(
  parameter int PC_WIDTH = 8,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [15:0]         instruction,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic                halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]       LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0]       FULL_CNT = CW'(DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(RESET_PC);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                discard_q, discard_d;
  logic                halted_q, halted_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [15:0]         inst_mem_q [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];

  logic issue_ok, fire, push, pop, halt_hit;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A new fetch is never started in a redirect cycle so the first fetch uses the new PC.
  assign issue_ok   = (count_q < FULL_CNT) && !halted_q && !redirect_valid;
  assign imem_req   = rst_n && (busy_q || issue_ok);
  assign imem_addr  = busy_q ? addr_q : pc_q;
  assign fire       = imem_req && imem_ack;
  assign push       = fire && !discard_q && !redirect_valid;
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;

  assign instruction = inst_mem_q[rd_ptr_q];
  assign inst_pc     = pc_mem_q[rd_ptr_q];
  assign halted      = halted_q;

`ifdef HALT_DETECT_EN
  assign halt_hit = push && (imem_rdata[15:12] == 4'hF);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    discard_d = discard_q;
    halted_d  = halted_q | halt_hit;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    if (imem_req && !imem_ack) begin
      busy_d = 1'b1;
      addr_d = imem_addr;
    end
    if (fire) begin
      busy_d    = 1'b0;
      discard_d = 1'b0;
      if (!discard_q) pc_d = pc_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    // Redirect wins; a request still in flight keeps its address but its data is dropped.
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      halted_d  = 1'b0;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      discard_d = imem_req && !imem_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= PC_RST;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      discard_q <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      discard_q <= discard_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= imem_addr;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch: vector table, corner sequences, random vs queue model.
module tb_inst_fetch;

  localparam int PW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [15:0]   instruction;
  logic [PW-1:0] inst_pc;
  logic          halted;

  always #5 clk = ~clk;

  inst_fetch #(.PC_WIDTH(PW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .inst_pc(inst_pc), .halted(halted)
  );

`ifdef HALT_DETECT_EN
  localparam bit HALT_FEATURE = 1'b1;
`else
  localparam bit HALT_FEATURE = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // memory model
  int          lat = 0;
  int          wait_cnt = 0;
  bit          hf_en = 1'b0;
  logic [7:0]  hf_addr = 8'h00;

  // reference model: queue of delivered-to-be entries plus fetch bookkeeping
  logic [7:0]  mq_pc [$];
  logic [15:0] mq_ins [$];
  logic [7:0]  m_pc, m_paddr;
  bit          m_pending, m_discard, m_halted;

  // captured DUT values for the most recent cycle
  logic        a_req, a_ack, a_valid, a_halted;
  logic [7:0]  a_addr, a_pc;
  logic [15:0] a_inst;
  int          dut_deliv;
  logic [7:0]  dut_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (hf_en && a == hf_addr) return 16'hF000 | {8'h00, a};
    return 16'h1000 + {8'h00, a};
  endfunction

  task automatic model_reset();
    mq_pc.delete();
    mq_ins.delete();
    m_pc = 8'h00; m_paddr = 8'h00;
    m_pending = 1'b0; m_discard = 1'b0; m_halted = 1'b0;
    wait_cnt = 0;
    dut_deliv = 0;
    dut_last = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instruction", 32'(instruction), 32'd0);
    chk("rst_inst_pc", 32'(inst_pc), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit rv, input logic [7:0] rpc, input bit rdy);
    bit         exp_req;
    logic [7:0] cur_addr;
    logic [15:0] word;
    redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy; imem_ack = 1'b0;
    #1;
    if (imem_req && wait_cnt >= lat) begin
      imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ack = 1'b0; imem_rdata = 16'($urandom);
    end
    #1;
    a_req = imem_req; a_ack = imem_ack; a_addr = imem_addr; a_valid = inst_valid;
    a_pc = inst_pc; a_inst = instruction; a_halted = halted;

    exp_req  = m_pending || (mq_pc.size() < DEPTH && !m_halted && !rv);
    cur_addr = m_pending ? m_paddr : m_pc;
    chk("m_req", 32'(a_req), 32'(exp_req));
    if (exp_req) chk("m_addr", 32'(a_addr), 32'(cur_addr));
    chk("m_valid", 32'(a_valid), 32'(mq_pc.size() > 0));
    if (mq_pc.size() > 0) begin
      chk("m_inst_pc", 32'(a_pc), 32'(mq_pc[0]));
      chk("m_instruction", 32'(a_inst), 32'(mq_ins[0]));
    end
    chk("m_halted", 32'(a_halted), 32'(m_halted));
    if (a_valid && rdy) begin dut_deliv++; dut_last = a_pc; end

    @(posedge clk);
    if (mq_pc.size() > 0 && rdy) begin void'(mq_pc.pop_front()); void'(mq_ins.pop_front()); end
    if (rv) begin
      mq_pc.delete(); mq_ins.delete();
      if (exp_req && !a_ack) begin
        m_paddr = cur_addr; m_pending = 1'b1; m_discard = 1'b1;
      end else begin
        m_pending = 1'b0; m_discard = 1'b0;
      end
      m_pc = rpc; m_halted = 1'b0;
    end else if (exp_req && a_ack) begin
      if (!m_discard) begin
        word = mem_word(cur_addr);
        mq_pc.push_back(cur_addr); mq_ins.push_back(word);
        if (HALT_FEATURE && word[15:12] == 4'hF) m_halted = 1'b1;
        m_pc = m_pc + 8'd1;
      end
      m_discard = 1'b0; m_pending = 1'b0;
    end else if (exp_req) begin
      m_paddr = cur_addr; m_pending = 1'b1;
    end
    if (a_req && !a_ack) wait_cnt++; else wait_cnt = 0;
    #1;
  endtask

  typedef struct {
    bit rst; int lat; bit rdy;
    bit exp_req; logic [7:0] exp_addr; bit exp_valid; logic [7:0] exp_pc; logic [15:0] exp_inst;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(bit rst, int l, bit rdy, bit er, logic [7:0] ea, bit ev, logic [7:0] ep, logic [15:0] ei);
    vec_t v;
    v.rst = rst; v.lat = l; v.rdy = rdy; v.exp_req = er; v.exp_addr = ea;
    v.exp_valid = ev; v.exp_pc = ep; v.exp_inst = ei;
    return v;
  endfunction

  initial begin
    logic [7:0] exp_e [4];
    bit found;
    int rnd_sel;
    logic [7:0] rpc;

    // zero latency, always ready: one instruction per cycle
    tbl.push_back(mk(1, 0, 1, 1, 8'h00, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 1, 8'h01, 1, 8'h00, 16'h1000));
    tbl.push_back(mk(0, 0, 1, 1, 8'h02, 1, 8'h01, 16'h1001));
    tbl.push_back(mk(0, 0, 1, 1, 8'h03, 1, 8'h02, 16'h1002));
    tbl.push_back(mk(0, 0, 1, 1, 8'h04, 1, 8'h03, 16'h1003));
    // latency 3 with backpressure: queue fills, requests stop, head stable
    tbl.push_back(mk(1, 3, 0, 1, 8'h00, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 3, 0, 1, 8'h00, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 3, 0, 1, 8'h00, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 3, 0, 1, 8'h00, 0, 8'h00, 16'h0000));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 3, 0, 1, 8'h01, 1, 8'h00, 16'h1000));
    tbl.push_back(mk(0, 3, 0, 0, 8'h00, 1, 8'h00, 16'h1000));
    tbl.push_back(mk(0, 3, 0, 0, 8'h00, 1, 8'h00, 16'h1000));
    tbl.push_back(mk(0, 3, 1, 0, 8'h00, 1, 8'h00, 16'h1000));
    tbl.push_back(mk(0, 3, 1, 1, 8'h02, 1, 8'h01, 16'h1001));
    tbl.push_back(mk(0, 3, 1, 1, 8'h02, 0, 8'h00, 16'h0000));

    rst_n = 1'b0;
    model_reset();
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      lat = tbl[i].lat;
      step(1'b0, 8'h00, tbl[i].rdy);
      chk($sformatf("tbl%0d_req", i), 32'(a_req), 32'(tbl[i].exp_req));
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), 32'(a_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_valid", i), 32'(a_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i), 32'(a_pc), 32'(tbl[i].exp_pc));
        chk($sformatf("tbl%0d_inst", i), 32'(a_inst), 32'(tbl[i].exp_inst));
      end
    end

    // redirect while a request to pc 5 is pending
    do_reset();
    lat = 0;
    repeat (5) step(1'b0, 8'h00, 1'b1);
    lat = 2;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h40, 1'b1);
    chk("C_pend_addr", 32'(a_addr), 32'h05);
    chk("C_pend_ack", 32'(a_ack), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("C_old_ack", 32'(a_ack), 32'd1);
    chk("C_old_addr", 32'(a_addr), 32'h05);
    chk("C_flushed", 32'(a_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("C_new_req", 32'(a_req), 32'd1);
    chk("C_new_addr", 32'(a_addr), 32'h40);
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 1'b1);
      if (a_valid) begin
        chk("C_first_pc", 32'(a_pc), 32'h40);
        chk("C_first_inst", 32'(a_inst), 32'h1040);
        found = 1'b1;
        break;
      end
    end
    chk("C_timeout", 32'(found), 32'd1);

    // redirect coinciding with ack and pop
    do_reset();
    lat = 1;
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h80, 1'b1);
    chk("D_pop_valid", 32'(a_valid), 32'd1);
    chk("D_pop_pc", 32'(a_pc), 32'h00);
    chk("D_ack", 32'(a_ack), 32'd1);
    chk("D_ack_addr", 32'(a_addr), 32'h01);
    step(1'b0, 8'h00, 1'b1);
    chk("D_empty", 32'(a_valid), 32'd0);
    chk("D_next_addr", 32'(a_addr), 32'h80);
    chk("D_deliv_once", 32'(dut_deliv), 32'd1);

    // PC wrap
    do_reset();
    lat = 0;
    exp_e[0] = 8'hFE; exp_e[1] = 8'hFF; exp_e[2] = 8'h00; exp_e[3] = 8'h01;
    step(1'b1, 8'hFE, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("E_req%0d", k), 32'(a_req), 32'd1);
      chk($sformatf("E_addr%0d", k), 32'(a_addr), 32'(exp_e[k]));
    end

    // halt opcode at pc 3
    do_reset();
    lat = 0; hf_en = 1'b1; hf_addr = 8'h03;
    repeat (10) step(1'b0, 8'h00, 1'b1);
    chk("F_deliv", 32'(dut_deliv), HALT_FEATURE ? 32'd4 : 32'd9);
    chk("F_last_pc", 32'(dut_last), HALT_FEATURE ? 32'h03 : 32'h08);
    chk("F_halted", 32'(a_halted), 32'(HALT_FEATURE));
    chk("F_req", 32'(a_req), 32'(!HALT_FEATURE));
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("F_clear_halted", 32'(a_halted), 32'd0);
    chk("F_refetch_req", 32'(a_req), 32'd1);
    chk("F_refetch_addr", 32'(a_addr), 32'h00);

    // randomized run against the model
    do_reset();
    hf_en = 1'b1; hf_addr = 8'h13;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) lat = $urandom_range(0, 3);
      rnd_sel = $urandom_range(0, 3);
      rpc = (rnd_sel == 0) ? 8'h10 : (rnd_sel == 1) ? 8'hFD : 8'($urandom);
      step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
